// File: rtl/rotation_kick_ctrl_pkg.sv
// Shared types for the rotation/wall-kick path: piece descriptor, kick offsets,
// piece indices and the controller state encoding.
package rotation_kick_ctrl_pkg;

    localparam int COORD_W    = 6;
    localparam int KICK_TESTS = 5;

    localparam logic [2:0] TETROMINO_I_IDX = 3'd0;
    localparam logic [2:0] TETROMINO_O_IDX = 3'd1;
    localparam logic [2:0] TETROMINO_T_IDX = 3'd2;
    localparam logic [2:0] TETROMINO_S_IDX = 3'd3;
    localparam logic [2:0] TETROMINO_Z_IDX = 3'd4;
    localparam logic [2:0] TETROMINO_J_IDX = 3'd5;
    localparam logic [2:0] TETROMINO_L_IDX = 3'd6;

    typedef struct packed {
        logic [2:0]                idx;
        logic [1:0]                rotation;
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
    } tetromino_ctrl;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
    } kick_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROTATE,
        ST_CHECK,
        ST_WAIT_CHK,
        ST_DONE
    } rk_state_e;

endpackage

// File: rtl/rotation_kick_ctrl_if.sv
// Handshake bundle between the kick controller and its two responders
// (rotate_tetromino and the collision checker).
interface rotation_kick_ctrl_if
    import rotation_kick_ctrl_pkg::*;
();
    logic          rot_enable;
    logic          rot_clockwise;
    tetromino_ctrl rot_t_in;
    tetromino_ctrl rot_t_out;
    logic          rot_success;
    logic          rot_done;
    logic          chk_req;
    tetromino_ctrl chk_t;
    logic          chk_ok;
    logic          chk_done;

    modport master (
        output rot_enable, rot_clockwise, rot_t_in, chk_req, chk_t,
        input  rot_t_out, rot_success, rot_done, chk_ok, chk_done
    );

    modport slave (
        input  rot_enable, rot_clockwise, rot_t_in, chk_req, chk_t,
        output rot_t_out, rot_success, rot_done, chk_ok, chk_done
    );
endinterface

// File: rtl/rotation_kick_ctrl_srs_kick_table.sv
// Combinational SRS wall-kick lookup (JLSTZ and I sets), returned in board
// coordinates where y grows downward. The O piece and test 0 always give (0,0).
module rotation_kick_ctrl_srs_kick_table
    import rotation_kick_ctrl_pkg::*;
(
    input  logic [2:0] idx,
    input  logic [1:0] from_rot,
    input  logic [1:0] to_rot,
    input  logic [2:0] k,
    output kick_t      kick
);
    // Every legal transition is one of four base rows, possibly negated.
    typedef enum logic [1:0] {TBL_JLSTZ_0R, TBL_JLSTZ_0L, TBL_I_0R, TBL_I_0L} tbl_e;

    tbl_e  tbl;
    logic  negate;
    logic  known;
    kick_t base;

    function automatic kick_t srs(input int x, input int y);
        kick_t r;
        r.x = COORD_W'(x);
        r.y = COORD_W'(-y);
        return r;
    endfunction

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        tbl    = TBL_JLSTZ_0R;
        negate = 1'b0;
        known  = 1'b1;
        if (idx == TETROMINO_O_IDX) begin
            known = 1'b0;
        end else begin
            unique case ({from_rot, to_rot})
                4'b00_01: begin tbl = (idx == TETROMINO_I_IDX) ? TBL_I_0R : TBL_JLSTZ_0R; negate = 1'b0; end
                4'b01_00: begin tbl = (idx == TETROMINO_I_IDX) ? TBL_I_0R : TBL_JLSTZ_0R; negate = 1'b1; end
                4'b01_10: begin tbl = (idx == TETROMINO_I_IDX) ? TBL_I_0L : TBL_JLSTZ_0R; negate = (idx != TETROMINO_I_IDX); end
                4'b10_01: begin tbl = (idx == TETROMINO_I_IDX) ? TBL_I_0L : TBL_JLSTZ_0R; negate = (idx == TETROMINO_I_IDX); end
                4'b10_11: begin tbl = (idx == TETROMINO_I_IDX) ? TBL_I_0R : TBL_JLSTZ_0L; negate = (idx == TETROMINO_I_IDX); end
                4'b11_10: begin tbl = (idx == TETROMINO_I_IDX) ? TBL_I_0R : TBL_JLSTZ_0L; negate = (idx != TETROMINO_I_IDX); end
                4'b11_00: begin tbl = (idx == TETROMINO_I_IDX) ? TBL_I_0L : TBL_JLSTZ_0L; negate = 1'b1; end
                4'b00_11: begin tbl = (idx == TETROMINO_I_IDX) ? TBL_I_0L : TBL_JLSTZ_0L; negate = 1'b0; end
                default:  known = 1'b0;
            endcase
        end
    end

    always_comb begin
        base = '0;
        unique case (tbl)
            TBL_JLSTZ_0R: case (k)
                3'd1: base = srs(-1,  0);
                3'd2: base = srs(-1,  1);
                3'd3: base = srs( 0, -2);
                3'd4: base = srs(-1, -2);
                default: base = '0;
            endcase
            TBL_JLSTZ_0L: case (k)
                3'd1: base = srs( 1,  0);
                3'd2: base = srs( 1,  1);
                3'd3: base = srs( 0, -2);
                3'd4: base = srs( 1, -2);
                default: base = '0;
            endcase
            TBL_I_0R: case (k)
                3'd1: base = srs(-2,  0);
                3'd2: base = srs( 1,  0);
                3'd3: base = srs(-2, -1);
                3'd4: base = srs( 1,  2);
                default: base = '0;
            endcase
            TBL_I_0L: case (k)
                3'd1: base = srs(-1,  0);
                3'd2: base = srs( 2,  0);
                3'd3: base = srs(-1,  2);
                3'd4: base = srs( 2, -1);
                default: base = '0;
            endcase
            default: base = '0;
        endcase

        kick = base;
        if (negate) begin
            kick.x = -base.x;
            kick.y = -base.y;
        end
        if (!known) kick = '0;
    end

endmodule

// File: rtl/rotation_kick_ctrl.sv
// Rotation initiator: drives the rotator handshake, then walks the SRS kick
// tests through the collision checker and reports one commit or reject.
module rotation_kick_ctrl
    import rotation_kick_ctrl_pkg::*;
#(
    parameter int NUM_KICKS = KICK_TESTS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    input  logic                 req_cw,
    input  tetromino_ctrl        cur,
    input  logic                 abort,
    output logic                 busy,
    rotation_kick_ctrl_if.master rsp,
    output logic                 result_valid,
    output logic                 result_ok,
    output tetromino_ctrl        result,
    output logic [2:0]           result_kick
);
    rk_state_e     state;
    logic [2:0]    k;
    logic [2:0]    k_next;
    tetromino_ctrl rot_q;
    tetromino_ctrl next_cand;
    kick_t         next_kick;
    logic          more_kicks;

    assign k_next = k + 3'd1;

    // rot_t_in doubles as the latched request piece for the whole transaction.
    rotation_kick_ctrl_srs_kick_table u_kick (
        .idx      (rsp.rot_t_in.idx),
        .from_rot (rsp.rot_t_in.rotation),
        .to_rot   (rot_q.rotation),
        .k        (k_next),
        .kick     (next_kick)
    );

    always_comb begin
        next_cand   = rot_q;
        next_cand.x = rot_q.x + next_kick.x;
        next_cand.y = rot_q.y + next_kick.y;
    end

    assign more_kicks = (k < 3'(NUM_KICKS - 1)) && (rsp.rot_t_in.idx != TETROMINO_O_IDX);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            k                 <= '0;
            rot_q             <= '0;
            busy              <= 1'b0;
            rsp.rot_enable    <= 1'b0;
            rsp.rot_clockwise <= 1'b0;
            rsp.rot_t_in      <= '0;
            rsp.chk_req       <= 1'b0;
            rsp.chk_t         <= '0;
            result_valid      <= 1'b0;
            result_ok         <= 1'b0;
            result            <= '0;
            result_kick       <= '0;
        end else if (abort) begin
            state          <= ST_IDLE;
            k              <= '0;
            busy           <= 1'b0;
            rsp.rot_enable <= 1'b0;
            rsp.chk_req    <= 1'b0;
            result_valid   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: if (req_valid) begin
                    rsp.rot_t_in      <= cur;
                    rsp.rot_clockwise <= req_cw;
                    rsp.rot_enable    <= 1'b1;
                    k                 <= '0;
                    busy              <= 1'b1;
                    state             <= ST_ROTATE;
                end
                ST_ROTATE: if (rsp.rot_done) begin
                    rsp.rot_enable <= 1'b0;
                    if (rsp.rot_success) begin
                        rot_q       <= rsp.rot_t_out;
                        rsp.chk_t   <= rsp.rot_t_out;   // test 0 is always (0,0)
                        rsp.chk_req <= 1'b1;
                        state       <= ST_CHECK;
                    end else begin
                        result_ok    <= 1'b0;
                        result       <= rsp.rot_t_in;
                        result_kick  <= '0;
                        result_valid <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
                ST_CHECK: begin
                    rsp.chk_req <= 1'b0;
                    state       <= ST_WAIT_CHK;
                end
                ST_WAIT_CHK: if (rsp.chk_done) begin
                    if (rsp.chk_ok) begin
                        result_ok    <= 1'b1;
                        result       <= rsp.chk_t;
                        result_kick  <= k;
                        result_valid <= 1'b1;
                        state        <= ST_DONE;
                    end else if (more_kicks) begin
                        k           <= k_next;
                        rsp.chk_t   <= next_cand;
                        rsp.chk_req <= 1'b1;
                        state       <= ST_CHECK;
                    end else begin
                        result_ok    <= 1'b0;
                        result       <= rsp.rot_t_in;
                        result_kick  <= '0;
                        result_valid <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
